modexp_sequencer: RTL and testbench
===================================

# modexp_sequencer

Synthesizable controller that runs one complete RSA modular exponentiation, result = message^exponent mod modulus. It sequences the Montgomery precompute units (`rtMod` for r and t, `modInv` for nprime0), streams all operands into `ModExp` word-serially, waits for completion, and collects the result. It replaces testbench-driven sequencing, so a host only supplies operands and a start pulse.

## Interface
- `WIDTH`, 4096: operand width in bits.
- `DATA_WIDTH`, 64: word width of the `ModExp` buffer ports.
- `WORDS`, WIDTH/DATA_WIDTH: words per operand (64).
- `COMPLETE_CODE`, 9: `exp_state` value meaning computation complete.
- `TIMEOUT_CYCLES`, 2^24: watchdog limit, used only with the macro.
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `message`, `exponent`, `modulus` in WIDTH: captured on the cycle `start` is accepted.
- `busy` out 1: high from the accept cycle until DONE exits.
- `done` out 1: one-cycle pulse when `result` is valid.
- `error` out 1: watchdog abort flag (macro only; otherwise tied 0).
- `result` out WIDTH: last result, held until the next accept or reset.
- `rt_go` out 1, `rt_mode` out 1, `rt_n` out WIDTH, `rt_r` in WIDTH, `rt_done` in 1: `rtMod` port. Mode 0 computes r, mode 1 computes t.
- `inv_go` out 1, `inv_n` out WIDTH, `inv_result` in 64, `inv_valid` in 1: `modInv` port.
- `m_buf`, `e_buf`, `n_buf`, `r_buf`, `t_buf` out DATA_WIDTH, `nprime0` out 64, `start_input`, `start_compute`, `get_result` out 1, `exp_state` in 5, `res_out` in DATA_WIDTH: `ModExp` port.

## Operation
- States: IDLE, CALC_R, CALC_T, CALC_N0, SEND_INPUT, WAIT_COMPUTE, READ_OUTPUT, DONE, plus ERROR with the macro. 4-bit state register.
- IDLE + `start`: latch the operands, clear `result`, go to CALC_R. `rt_n` and `inv_n` always drive the latched modulus.
- CALC_R: `rt_go` pulses high on the first cycle only, with `rt_mode`=0. On `rt_done`, latch `rt_r` into r and go to CALC_T.
- CALC_T: same sequence with `rt_mode`=1. On `rt_done`, latch `rt_r` into t and go to CALC_N0.
- CALC_N0: `inv_go` pulses on the first cycle. On `inv_valid`, latch `inv_result` into `nprime0` and go to SEND_INPUT.
- A done or valid strobe that arrives on the same cycle as the go pulse is accepted.
- SEND_INPUT: a word counter k runs 0..WORDS-1. In cycle k, all five buffers drive word k, i.e. bits [k*DATA_WIDTH +: DATA_WIDTH]. `start_input`=1 throughout. After k=WORDS-1, go to WAIT_COMPUTE.
- WAIT_COMPUTE: `start_compute`=1 and `get_result`=1, held through READ_OUTPUT. When `exp_state`==COMPLETE_CODE, go to READ_OUTPUT.
- READ_OUTPUT: counter j runs 0..WORDS. At j=0, `res_out` is discarded (one-cycle ModExp output latency). For j≥1, `result[(j-1)*DATA_WIDTH +: DATA_WIDTH]` ← `res_out`.
- DONE: `done`=1 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored, including during DONE.
- Operand inputs may change freely after the accept cycle.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, and the latched r, t and `nprime0` are 0.
- An asynchronous reset mid-operation aborts immediately; the submodules are not drained.
- Accept to `rt_go`: 1 cycle. `rt_done` to the next go pulse: 1 cycle.
- SEND_INPUT lasts exactly WORDS cycles. READ_OUTPUT lasts exactly WORDS+1 cycles.
- Last result word captured → `done` on the next cycle, with `busy` high during the `done` cycle.
- Fixed overhead excluding submodule latency: 1+1+1+1+WORDS+1+(WORDS+1)+1 cycles.

## Configuration
- `MODEXP_SEQ_TIMEOUT_EN`, defined:
  - A 32-bit watchdog restarts on every state change.
  - In CALC_R, CALC_T, CALC_N0 or WAIT_COMPUTE, reaching TIMEOUT_CYCLES moves the FSM to ERROR.
  - In ERROR, `error`=1 and `busy`=0, all strobes are 0, and `result` stays 0.
  - The next accepted `start` clears `error`.
- Undefined: no watchdog, the FSM waits indefinitely, `error` is constant 0, and no ERROR state exists.

## Test plan
- m=8, e=13, n=77 with the real `rtMod`, `modInv` and `ModExp` → single `done` pulse, `result`=50, `busy` falls the cycle after `done`.
- Stubbed submodules with `rt_done`/`inv_valid` after 5 cycles → exactly one `rt_go` pulse with `rt_mode` 0 then 1, one `inv_go` pulse, and r/t/`nprime0` equal to the stub values.
- Stub ModExp recording buffers → 64 consecutive cycles with `start_input`=1, and word k of every operand appears at cycle k. Word 63 of a 4096-bit modulus with MSB set is 0x8000…0000.
- `res_out` stub emitting j at READ_OUTPUT count j → `result` word i = i+1 for i in 0..63, and the j=0 value is dropped.
- `start` pulsed during CALC_T and during DONE → ignored, one `done` only. Reset asserted in SEND_INPUT → all outputs 0 immediately, and a new `start` completes normally.
- With the macro and TIMEOUT_CYCLES=100, `rt_done` never asserted → `error`=1 at cycle 101 of CALC_R, `busy`=0, and the next `start` clears `error`.

Source files
------------

// File: rtl/modexp_sequencer.sv
// modexp_sequencer: runs rtMod (r, t), modInv (nprime0) and word-serial ModExp for one result = m^e mod n.
// Define MODEXP_SEQ_TIMEOUT_EN to add a watchdog that aborts stalled submodule waits into ERROR.
module modexp_sequencer #(
    parameter int          WIDTH          = 4096,
    parameter int          DATA_WIDTH     = 64,
    parameter int          WORDS          = WIDTH / DATA_WIDTH,
    parameter logic [4:0]  COMPLETE_CODE  = 5'd9,
    parameter int unsigned TIMEOUT_CYCLES = 32'd16777216
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      message,
    input  logic [WIDTH-1:0]      exponent,
    input  logic [WIDTH-1:0]      modulus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [WIDTH-1:0]      result,
    output logic                  rt_go,
    output logic                  rt_mode,
    output logic [WIDTH-1:0]      rt_n,
    input  logic [WIDTH-1:0]      rt_r,
    input  logic                  rt_done,
    output logic                  inv_go,
    output logic [WIDTH-1:0]      inv_n,
    input  logic [63:0]           inv_result,
    input  logic                  inv_valid,
    output logic [DATA_WIDTH-1:0] m_buf,
    output logic [DATA_WIDTH-1:0] e_buf,
    output logic [DATA_WIDTH-1:0] n_buf,
    output logic [DATA_WIDTH-1:0] r_buf,
    output logic [DATA_WIDTH-1:0] t_buf,
    output logic [63:0]           nprime0,
    output logic                  start_input,
    output logic                  start_compute,
    output logic                  get_result,
    input  logic [4:0]            exp_state,
    input  logic [DATA_WIDTH-1:0] res_out
);
    localparam int CW = $clog2(WORDS + 1);
    localparam logic [CW-1:0] LAST = CW'(WORDS - 1);
    localparam logic [CW-1:0] FULL = CW'(WORDS);

    typedef enum logic [3:0] {
        IDLE, CALC_R, CALC_T, CALC_N0, SEND_INPUT, WAIT_COMPUTE, READ_OUTPUT, DONE
`ifdef MODEXP_SEQ_TIMEOUT_EN
        , ERROR
`endif
    } state_t;

    state_t            state_q, state_d;
    logic              entered_q, entered_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  m_q, m_d, e_q, e_d, n_q, n_d, r_q, r_d, t_q, t_d, res_q, res_d;
    logic [63:0]       np_q, np_d;
    logic              send;

`ifdef MODEXP_SEQ_TIMEOUT_EN
    logic [31:0] wd_q;
    logic        timeout;
    assign timeout = state_q inside {CALC_R, CALC_T, CALC_N0, WAIT_COMPUTE} && wd_q == TIMEOUT_CYCLES - 1;
    assign error   = state_q == ERROR;
    // Watchdog restarts on every state change, so it times each wait individually.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wd_q <= '0;
        else       wd_q <= (state_d != state_q) ? '0 : wd_q + 32'd1;
    end
`else
    logic unused_cfg;
    assign unused_cfg = |TIMEOUT_CYCLES;
    assign error      = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        e_d       = e_q;
        n_d       = n_q;
        r_d       = r_q;
        t_d       = t_q;
        np_d      = np_q;
        res_d     = res_q;
        case (state_q)
            CALC_R:       if (rt_done) begin
                              r_d     = rt_r;
                              state_d = CALC_T;
                          end
            CALC_T:       if (rt_done) begin
                              t_d     = rt_r;
                              state_d = CALC_N0;
                          end
            CALC_N0:      if (inv_valid) begin
                              np_d    = inv_result;
                              state_d = SEND_INPUT;
                          end
            SEND_INPUT:   begin
                              cnt_d   = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
                              state_d = (cnt_q == LAST) ? WAIT_COMPUTE : SEND_INPUT;
                          end
            WAIT_COMPUTE: if (exp_state == COMPLETE_CODE) state_d = READ_OUTPUT;
            // Word 0 of the read is ModExp's pipeline latency, so word j lands at j-1.
            READ_OUTPUT:  begin
                              if (cnt_q != '0) res_d[(int'(cnt_q) - 1) * DATA_WIDTH +: DATA_WIDTH] = res_out;
                              cnt_d   = (cnt_q == FULL) ? '0 : cnt_q + 1'b1;
                              state_d = (cnt_q == FULL) ? DONE : READ_OUTPUT;
                          end
            DONE:         state_d = IDLE;
            default:      if (start) begin
                              m_d     = message;
                              e_d     = exponent;
                              n_d     = modulus;
                              res_d   = '0;
                              state_d = CALC_R;
                          end
        endcase
`ifdef MODEXP_SEQ_TIMEOUT_EN
        if (timeout) state_d = ERROR;
`endif
        entered_d = state_d != state_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            entered_q <= 1'b0;
            cnt_q     <= '0;
            m_q       <= '0;
            e_q       <= '0;
            n_q       <= '0;
            r_q       <= '0;
            t_q       <= '0;
            np_q      <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            entered_q <= entered_d;
            cnt_q     <= cnt_d;
            m_q       <= m_d;
            e_q       <= e_d;
            n_q       <= n_d;
            r_q       <= r_d;
            t_q       <= t_d;
            np_q      <= np_d;
            res_q     <= res_d;
        end
    end

    assign send          = state_q == SEND_INPUT;
    assign busy          = state_q != IDLE && !error;
    assign done          = state_q == DONE;
    assign rt_go         = entered_q && (state_q == CALC_R || state_q == CALC_T);
    assign rt_mode       = state_q == CALC_T;
    assign inv_go        = entered_q && state_q == CALC_N0;
    assign rt_n          = n_q;
    assign inv_n         = n_q;
    assign nprime0       = np_q;
    assign result        = res_q;
    assign start_input   = send;
    assign start_compute = state_q == WAIT_COMPUTE || state_q == READ_OUTPUT;
    assign get_result    = start_compute;
    assign m_buf         = send ? m_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign e_buf         = send ? e_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign n_buf         = send ? n_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign r_buf         = send ? r_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign t_buf         = send ? t_q[int'(cnt_q) * DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule

// File: tb/tb_modexp_sequencer.sv
// tb_modexp_sequencer: directed bench with stubbed rtMod/modInv/ModExp responders.
module tb_modexp_sequencer;
    localparam int W = 4096, DW = 64, WORDS = 64;
    localparam logic [63:0] INV_VAL = 64'h0123_4567_89AB_CDEF;

    logic clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [W-1:0] message = '0, exponent = '0, modulus = '0, rt_r = '0;
    logic rt_done = 1'b0, inv_valid = 1'b0;
    logic [63:0] inv_result = '0;
    logic [4:0] exp_state = '0;
    logic [DW-1:0] res_out = '0;
    logic busy, done, error, rt_go, rt_mode, inv_go, start_input, start_compute, get_result;
    logic [W-1:0] result, rt_n, inv_n;
    logic [DW-1:0] m_buf, e_buf, n_buf, r_buf, t_buf;
    logic [63:0] nprime0;

    logic [W-1:0] m_exp, e_exp, n_exp, r_val, t_val, res_at_done, res_c1, want;
    int rt_go_n, inv_go_n, go_cyc, bad_n, si_n, si_first, si_last, buf_bad, done_n, done_cyc;
    logic mode0, mode1, busy_at_done, busy_after;
    logic [63:0] n63, np_seen;
    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    modexp_sequencer #(.WIDTH(W), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .start(start), .message(message), .exponent(exponent),
        .modulus(modulus), .busy(busy), .done(done), .error(error), .result(result),
        .rt_go(rt_go), .rt_mode(rt_mode), .rt_n(rt_n), .rt_r(rt_r), .rt_done(rt_done),
        .inv_go(inv_go), .inv_n(inv_n), .inv_result(inv_result), .inv_valid(inv_valid),
        .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
        .nprime0(nprime0), .start_input(start_input), .start_compute(start_compute),
        .get_result(get_result), .exp_state(exp_state), .res_out(res_out)
    );

    function automatic logic [W-1:0] exp_result(input logic [63:0] rx);
        logic [W-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*DW +: DW] = 64'(i + 1) ^ rx;
        return v;
    endfunction

    // Accept at cycle 0; stubs answer rt/inv after lat cycles and exp_state after clat WAIT cycles.
    task automatic run_txn(input int lat, input int clat, input int inj_a, input int inj_b,
                           input int abort_at, input logic [63:0] rx);
        int rt_t, inv_t, wc, rj;
        logic arm;
        rt_t = -1; inv_t = -1; wc = 0; rj = -1; arm = 1'b0;
        rt_go_n = 0; inv_go_n = 0; go_cyc = 0; bad_n = 0; mode0 = 1'b1; mode1 = 1'b0;
        si_n = 0; si_first = 0; si_last = 0; buf_bad = 0; n63 = '0; np_seen = '0;
        done_n = 0; done_cyc = 0; busy_at_done = 1'b0; busy_after = 1'b1; res_at_done = '0; res_c1 = '1;
        exp_state = '0; rt_done = 1'b0; inv_valid = 1'b0; res_out = '0;
        @(negedge clk);
        message = m_exp; exponent = e_exp; modulus = n_exp; start = 1'b1;
        for (int cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                message = ~m_exp; exponent = ~e_exp; modulus = ~n_exp; res_c1 = result;
            end
            if (cyc == abort_at) begin
                reset = 1'b1;
                break;
            end
            start = (cyc == inj_a || cyc == inj_b);
            if (rt_go) begin
                rt_go_n++;
                if (rt_go_n == 1) begin go_cyc = cyc; mode0 = rt_mode; end else mode1 = rt_mode;
                if (rt_n !== n_exp) bad_n++;
                rt_t = lat;
            end
            rt_done = rt_t == 0;
            rt_r = rt_mode ? t_val : r_val;
            if (rt_t >= 0) rt_t--;
            if (inv_go) begin
                inv_go_n++;
                if (inv_n !== n_exp) bad_n++;
                inv_t = lat;
            end
            inv_valid = inv_t == 0;
            inv_result = INV_VAL;
            if (inv_t >= 0) inv_t--;
            if (start_input) begin
                if (si_n == 0) si_first = cyc;
                si_last = cyc;
                if (m_buf !== m_exp[si_n*DW +: DW] || e_buf !== e_exp[si_n*DW +: DW] ||
                    n_buf !== n_exp[si_n*DW +: DW] || r_buf !== r_val[si_n*DW +: DW] ||
                    t_buf !== t_val[si_n*DW +: DW]) buf_bad++;
                if (si_n == WORDS - 1) begin n63 = n_buf; np_seen = nprime0; end
                si_n++;
            end
            if (rj >= 0) rj++;
            if (arm) begin rj = 0; arm = 1'b0; end
            res_out = (rj < 0) ? '0 : (64'(rj) ^ rx);
            if (start_compute && get_result && exp_state != 5'd9) begin
                wc++;
                if (wc == clat) begin exp_state = 5'd9; arm = 1'b1; end
            end
            if (done) begin
                done_n++; done_cyc = cyc; busy_at_done = busy; res_at_done = result;
            end
            if (done_n > 0 && cyc == done_cyc + 1) busy_after = busy;
            if (done_n > 0 && cyc == done_cyc + 3) break;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, error, rt_go, rt_mode, inv_go, start_input, start_compute, get_result} !== 9'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 000000000",
                     {busy, done, error, rt_go, rt_mode, inv_go, start_input, start_compute, get_result});
        end
        checks++;
        if ({m_buf, e_buf, n_buf, r_buf, t_buf, nprime0} !== '0) begin
            errors++; $display("FAIL reset_buffers: nonzero buffers, m_buf=%h nprime0=%h required 0", m_buf, nprime0);
        end
        checks++;
        if ({result, rt_n, inv_n} !== '0) begin
            errors++; $display("FAIL reset_wide: result/rt_n/inv_n nonzero, result[63:0]=%h required 0", result[63:0]);
        end
        @(negedge clk) reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b required 0", busy); end
    endtask

    task automatic test_precompute();
        run_txn(5, 3, 0, 0, 0, 64'h0);
        checks++;
        if (rt_go_n !== 2) begin errors++; $display("FAIL rt_go_count: got %0d required 2", rt_go_n); end
        checks++;
        if (go_cyc !== 1) begin errors++; $display("FAIL accept_to_rt_go: got cycle %0d required 1", go_cyc); end
        checks++;
        if ({mode0, mode1} !== 2'b01) begin errors++; $display("FAIL rt_mode_seq: got %b required 01", {mode0, mode1}); end
        checks++;
        if (inv_go_n !== 1) begin errors++; $display("FAIL inv_go_count: got %0d required 1", inv_go_n); end
        checks++;
        if (bad_n !== 0) begin errors++; $display("FAIL latched_modulus: %0d go pulses saw wrong n, required 0", bad_n); end
        checks++;
        if (np_seen !== INV_VAL) begin errors++; $display("FAIL nprime0: got %h required %h", np_seen, INV_VAL); end
    endtask

    task automatic test_send_input();
        run_txn(5, 3, 0, 0, 0, 64'h0);
        checks++;
        if (si_n !== WORDS) begin errors++; $display("FAIL send_len: got %0d cycles required %0d", si_n, WORDS); end
        checks++;
        if (si_first !== 19 || si_last !== 82) begin
            errors++; $display("FAIL send_window: got %0d..%0d required 19..82", si_first, si_last);
        end
        checks++;
        if (buf_bad !== 0) begin errors++; $display("FAIL send_words: %0d bad words required 0", buf_bad); end
        checks++;
        if (n63 !== 64'h8000_0000_0000_0000) begin
            errors++; $display("FAIL n_word63: got %h required 8000000000000000", n63);
        end
    endtask

    task automatic test_read_output();
        run_txn(5, 3, 0, 0, 0, 64'h0);
        want = exp_result(64'h0);
        checks++;
        if (done_n !== 1 || done_cyc !== 151) begin
            errors++; $display("FAIL done_timing: got %0d pulses at cycle %0d required 1 at 151", done_n, done_cyc);
        end
        checks++;
        if ({busy_at_done, busy_after} !== 2'b10) begin
            errors++; $display("FAIL busy_edges: got done/after=%b required 10", {busy_at_done, busy_after});
        end
        checks++;
        if (res_at_done[63:0] !== 64'd1) begin
            errors++; $display("FAIL first_word_drop: got %h required 1", res_at_done[63:0]);
        end
        checks++;
        if (res_at_done !== want) begin
            errors++; $display("FAIL result_words: word63 got %h required %h", res_at_done[W-1 -: 64], want[W-1 -: 64]);
        end
        checks++;
        if (result !== want) begin errors++; $display("FAIL result_hold: word0 got %h required %h", result[63:0], want[63:0]); end
    endtask

    task automatic test_zero_latency();
        run_txn(0, 1, 0, 0, 0, 64'h5A5A_5A5A_0000_FFFF);
        want = exp_result(64'h5A5A_5A5A_0000_FFFF);
        checks++;
        if (done_n !== 1 || done_cyc !== 134) begin
            errors++; $display("FAIL same_cycle_strobe: got %0d pulses at cycle %0d required 1 at 134", done_n, done_cyc);
        end
        checks++;
        if (rt_go_n !== 2 || inv_go_n !== 1) begin
            errors++; $display("FAIL same_cycle_gos: got rt %0d inv %0d required 2 1", rt_go_n, inv_go_n);
        end
        checks++;
        if (res_at_done !== want || buf_bad !== 0) begin
            errors++; $display("FAIL same_cycle_result: word0 got %h required %h bad=%0d", res_at_done[63:0], want[63:0], buf_bad);
        end
    endtask

    task automatic test_ignore_start();
        run_txn(5, 3, 9, 151, 0, 64'hC0DE_0000_0000_0000);
        want = exp_result(64'hC0DE_0000_0000_0000);
        checks++;
        if (done_n !== 1 || rt_go_n !== 2) begin
            errors++; $display("FAIL ignore_start: got done %0d rt_go %0d required 1 2", done_n, rt_go_n);
        end
        checks++;
        if (busy !== 1'b0 || busy_after !== 1'b0) begin
            errors++; $display("FAIL ignore_start_idle: got busy %b/%b required 0/0", busy_after, busy);
        end
        checks++;
        if (res_at_done !== want) begin
            errors++; $display("FAIL ignore_start_result: word0 got %h required %h", res_at_done[63:0], want[63:0]);
        end
    endtask

    task automatic test_back_to_back();
        run_txn(5, 3, 0, 0, 0, 64'h1111_2222_3333_4444);
        run_txn(5, 3, 0, 0, 0, 64'h9999_8888_7777_6666);
        want = exp_result(64'h9999_8888_7777_6666);
        checks++;
        if (res_c1 !== '0) begin errors++; $display("FAIL result_clear: word0 got %h required 0", res_c1[63:0]); end
        checks++;
        if (done_cyc !== 151 || res_at_done !== want) begin
            errors++; $display("FAIL second_txn: cycle %0d word0 %h required 151 %h", done_cyc, res_at_done[63:0], want[63:0]);
        end
    endtask

    task automatic test_reset_mid();
        run_txn(5, 3, 0, 0, 30, 64'h0);
        #1;
        checks++;
        if ({busy, done, error, rt_go, inv_go, start_input, start_compute, get_result} !== 8'b0 ||
            {m_buf, n_buf, nprime0} !== '0 || {result, rt_n} !== '0) begin
            errors++; $display("FAIL abort_outputs: busy=%b start_input=%b m_buf=%h required all 0", busy, start_input, m_buf);
        end
        @(negedge clk) reset = 1'b0;
        run_txn(5, 3, 0, 0, 0, 64'h0F0F_0000_0000_0001);
        want = exp_result(64'h0F0F_0000_0000_0001);
        checks++;
        if (done_n !== 1 || done_cyc !== 151 || res_at_done !== want) begin
            errors++; $display("FAIL after_abort: %0d pulses at %0d word0 %h required 1 at 151 %h",
                               done_n, done_cyc, res_at_done[63:0], want[63:0]);
        end
    endtask

`ifdef MODEXP_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        logic e100, e101, b101;
        exp_state = '0; rt_done = 1'b0; inv_valid = 1'b0;
        @(negedge clk);
        modulus = n_exp; start = 1'b1;
        for (int cyc = 1; cyc <= 101; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (cyc == 100) e100 = error;
            if (cyc == 101) begin e101 = error; b101 = busy; end
        end
        checks++;
        if ({e100, e101, b101} !== 3'b010) begin
            errors++; $display("FAIL watchdog: got err100/err101/busy=%b required 010", {e100, e101, b101});
        end
        checks++;
        if (result !== '0 || rt_go !== 1'b0) begin errors++; $display("FAIL error_quiet: result/strobe nonzero, required 0"); end
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        checks++;
        if ({error, busy} !== 2'b01) begin errors++; $display("FAIL error_clear: got error/busy=%b required 01", {error, busy}); end
        reset = 1'b1;
        @(negedge clk) reset = 1'b0;
    endtask
`endif

    initial begin
        for (int k = 0; k < WORDS; k++) begin
            m_exp[k*DW +: DW] = {32'(32'h1111_0000 + k), 32'(32'hA5A5_0000 + k)};
            e_exp[k*DW +: DW] = {32'(32'h2222_0000 + k), 32'(32'h0000_00E0 + k)};
            n_exp[k*DW +: DW] = (k == WORDS - 1) ? 64'h8000_0000_0000_0000 : {32'(32'h3333_0000 + k), 32'h1};
            r_val[k*DW +: DW] = {32'(32'h5151_0000 + k), 32'(32'hFFFF_0000 + k)};
            t_val[k*DW +: DW] = {32'(32'h7373_0000 + k), 32'(32'h0BAD_0000 + k)};
        end
        test_reset();
        test_precompute();
        test_send_input();
        test_read_output();
        test_zero_latency();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
`ifdef MODEXP_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
